// File: rtl/elevator_pkg.sv
// Shared types and default sizes for the elevator request scheduler.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS = 16;
  localparam int unsigned DEF_FLOOR_W    = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DOOR     = 2'd2,
    HOLD     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/elevator_floor_select.sv
// Combinational SCAN selector: next floor in the travel direction, else reverse.
module elevator_floor_select
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  sched_dir,
  output logic [FLOOR_W-1:0]    target,
  output logic                  target_found,
  output logic                  dir_flip
);

  logic [FLOOR_W-1:0] above;
  logic [FLOOR_W-1:0] below;
  logic               has_above;
  logic               has_below;
  logic               here;

  // Nearest pending floor above, nearest below, and a call at the car itself.
  always_comb begin
    above     = '0;
    below     = '0;
    has_above = 1'b0;
    has_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) == current_floor) begin
          here = 1'b1;
        end else if (FLOOR_W'(i) < current_floor) begin
          below     = FLOOR_W'(i);
          has_below = 1'b1;
        end else if (!has_above) begin
          above     = FLOOR_W'(i);
          has_above = 1'b1;
        end
      end
    end
  end

  always_comb begin
    target       = '0;
    target_found = 1'b0;
    dir_flip     = 1'b0;
    if (here) begin
      target       = current_floor;
      target_found = 1'b1;
    end else begin
      case (sched_dir)
        DIR_UP: begin
          if (has_above) begin
            target       = above;
            target_found = 1'b1;
          end else if (has_below) begin
            target       = below;
            target_found = 1'b1;
            dir_flip     = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (has_below) begin
            target       = below;
            target_found = 1'b1;
          end else if (has_above) begin
            target       = above;
            target_found = 1'b1;
            dir_flip     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Call latching, SCAN dispatch and door dwell for the elevator controller.
// Optional fire-recall mode is enabled by defining EMERGENCY_RECALL_EN.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W      = DEF_FLOOR_W,
  parameter int unsigned DWELL_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef EMERGENCY_RECALL_EN
  input  logic                  fire_recall,
`endif
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  complete,
  input  logic                  door_alert,
  input  logic                  weigh_alert,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  req_valid,
  output logic                  sched_dir,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  sched_state_t          state_q, state_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  req_valid_q, req_valid_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  served_q, served_d;
  logic                  door_open_q, door_open_d;
  logic                  busy_q, busy_d;

  logic [FLOOR_W-1:0]    sel_target;
  logic                  sel_found;
  logic                  sel_flip;
  logic                  clr_en;
  logic [FLOOR_W-1:0]    clr_floor;
  logic [NUM_FLOORS-1:0] clr_mask;

  elevator_floor_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_select (
    .pending       (pending_q),
    .current_floor (current_floor),
    .sched_dir     (dir_q),
    .target        (sel_target),
    .target_found  (sel_found),
    .dir_flip      (sel_flip)
  );

  // served_q marks a door opened for a call, so that floor's new calls are absorbed.
  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    served_d    = served_q;
    clr_en      = 1'b0;
    clr_floor   = req_floor_q;

    if (door_alert || weigh_alert) begin
      state_d     = HOLD;
      req_valid_d = 1'b0;
      cnt_d       = '0;
      served_d    = 1'b0;
    end
`ifdef EMERGENCY_RECALL_EN
    else if (fire_recall) begin
      served_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          req_floor_d = '0;
          if (current_floor == '0) begin
            state_d = DOOR;
            cnt_d   = '0;
          end else begin
            state_d     = DISPATCH;
            req_valid_d = 1'b1;
          end
        end
        DISPATCH: begin
          if (req_floor_q != '0) begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
          end else if (complete && current_floor == '0) begin
            state_d     = DOOR;
            req_valid_d = 1'b0;
            cnt_d       = '0;
          end
        end
        DOOR:    cnt_d = CNT_W'(DWELL_CYCLES - 1);
        HOLD: begin
          state_d = DOOR;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
`endif
    else begin
      unique case (state_q)
        IDLE: begin
          if (sel_found) begin
            req_floor_d = sel_target;
            if (sel_target == current_floor) begin
              state_d   = DOOR;
              cnt_d     = '0;
              served_d  = 1'b1;
              clr_en    = 1'b1;
              clr_floor = sel_target;
            end else begin
              state_d     = DISPATCH;
              req_valid_d = 1'b1;
              dir_d       = dir_q ^ sel_flip;
            end
          end
        end
        DISPATCH: begin
          if (complete && current_floor == req_floor_q) begin
            state_d     = DOOR;
            req_valid_d = 1'b0;
            cnt_d       = '0;
            served_d    = 1'b1;
            clr_en      = 1'b1;
          end
        end
        DOOR: begin
          clr_en = served_q;
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            served_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          state_d = DOOR;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end

    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      clr_mask[i] = clr_en && (FLOOR_W'(i) == clr_floor);
    end
    pending_d = (pending_q | call_req) & ~clr_mask;
`ifdef EMERGENCY_RECALL_EN
    if (fire_recall) pending_d = '0;
`endif

    door_open_d = (state_d == DOOR) || (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_q       <= DIR_UP;
      pending_q   <= '0;
      cnt_q       <= '0;
      served_q    <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      served_q    <= served_d;
      door_open_q <= door_open_d;
      busy_q      <= busy_d;
    end
  end

  assign request_floor = req_floor_q;
  assign req_valid     = req_valid_q;
  assign sched_dir     = dir_q;
  assign pending       = pending_q;
  assign door_open     = door_open_q;
  assign busy          = busy_q;

endmodule
